// File: rtl/frame_stream_reader_if.sv
// Pixel stream handshake from frame_stream_reader into the maxpool/zeropad/quantize chain.
// The reader drives the master side and the downstream consumer drives the slave side.
interface frame_stream_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_pixel;
  logic                  out_line_last;
  logic                  out_frame_first;
  logic                  out_frame_last;

  modport master (
    output out_valid,
    output out_pixel,
    output out_line_last,
    output out_frame_first,
    output out_frame_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_pixel,
    input  out_line_last,
    input  out_frame_first,
    input  out_frame_last,
    output out_ready
  );
endinterface

// File: rtl/frame_stream_reader.sv
// BRAM frame reader: on a bank-swap edge it streams one frame through a credit-checked skid FIFO.
// Define FRAME_STREAM_CHECKSUM_EN to build the per-frame 16-bit pixel checksum on checksum_o.
module frame_stream_reader #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int ADDR_FRAME = 19,
  parameter int DATA_WIDTH = 8,
  parameter int READ_LAT   = 1,
  parameter int SKID_DEPTH = 8
) (
  input  logic                  clk_in_100,
  input  logic                  arst_n,
  input  logic                  en,
  input  logic                  swap_i,
  output logic [ADDR_FRAME-1:0] addr_o,
  output logic                  rd_en_o,
  input  logic [DATA_WIDTH-1:0] din_i,
  frame_stream_reader_if.master stream,
  output logic                  busy,
  output logic [7:0]            swap_miss_cnt,
  output logic [15:0]           checksum_o
);

  localparam int F_SIZE = H_ACTIVE * V_ACTIVE;
  localparam int PTR_W  = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CNT_W  = $clog2(SKID_DEPTH + 1);
  localparam int COL_W  = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int ROW_W  = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  localparam logic [ADDR_FRAME-1:0] LAST_ADDR = ADDR_FRAME'(F_SIZE - 1);
  localparam logic [CNT_W:0]        DEPTH_LIM = (CNT_W + 1)'(SKID_DEPTH);
  localparam logic [COL_W-1:0]      COL_LAST  = COL_W'(H_ACTIVE - 1);
  localparam logic [ROW_W-1:0]      ROW_LAST  = ROW_W'(V_ACTIVE - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                state, state_next;
  logic                  swap_q, swap_rise;
  logic                  issue, miss_inc, credit_ok;
  logic [ADDR_FRAME-1:0] issue_addr;
  logic [READ_LAT-1:0]   lat_pipe;
  logic [CNT_W-1:0]      inflight, fifo_count;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] fifo_mem [SKID_DEPTH];
  logic                  push, pop;
  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;

  assign swap_rise = swap_i & ~swap_q;
  // Reads in flight plus entries already queued must fit in the FIFO, so a push can never overflow.
  assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_count}) < DEPTH_LIM;
  assign push      = lat_pipe[READ_LAT-1];
  assign pop       = stream.out_valid & stream.out_ready;

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    miss_inc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (swap_rise) begin
          if (en) state_next = READ;
          else    miss_inc   = 1'b1;
        end
      end
      READ: begin
        issue    = en & credit_ok;
        miss_inc = swap_rise;
        if (issue && issue_addr == LAST_ADDR) state_next = DRAIN;
      end
      DRAIN: begin
        miss_inc = swap_rise;
        if (inflight == '0 && (fifo_count == '0 || (fifo_count == CNT_W'(1) && pop)))
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in_100 or negedge arst_n) begin
    if (!arst_n) begin
      state         <= IDLE;
      swap_q        <= 1'b0;
      issue_addr    <= '0;
      swap_miss_cnt <= '0;
    end else begin
      state  <= state_next;
      swap_q <= swap_i;
      if (state == IDLE && state_next == READ)
        issue_addr <= '0;
      else if (issue)
        issue_addr <= (issue_addr == LAST_ADDR) ? '0 : issue_addr + 1'b1;
      if (miss_inc && swap_miss_cnt != 8'hFF)
        swap_miss_cnt <= swap_miss_cnt + 8'd1;
    end
  end

  assign rd_en_o = issue;
  assign addr_o  = issue_addr;
  assign busy    = (state != IDLE);

  // Each issued read rides a valid bit down the pipe and lands in the FIFO as it falls out the end.
  always_ff @(posedge clk_in_100 or negedge arst_n) begin
    if (!arst_n) begin
      lat_pipe   <= '0;
      inflight   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      lat_pipe   <= (lat_pipe << 1) | READ_LAT'(issue);
      inflight   <= inflight + CNT_W'(issue) - CNT_W'(push);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_in_100) begin
    if (push) fifo_mem[wr_ptr] <= din_i;
  end

  assign stream.out_valid = (fifo_count != '0);
  assign stream.out_pixel = stream.out_valid ? fifo_mem[rd_ptr] : '0;

  always_ff @(posedge clk_in_100 or negedge arst_n) begin
    if (!arst_n) begin
      col <= '0;
      row <= '0;
    end else if (pop) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign stream.out_line_last   = stream.out_valid && (col == COL_LAST);
  assign stream.out_frame_first = stream.out_valid && (col == '0) && (row == '0);
  assign stream.out_frame_last  = stream.out_valid && (col == COL_LAST) && (row == ROW_LAST);

`ifdef FRAME_STREAM_CHECKSUM_EN
  logic [15:0] csum_acc;
  logic [15:0] csum_sum;

  // The first pixel of a frame restarts the sum, so the published value covers exactly one frame.
  assign csum_sum = (stream.out_frame_first ? 16'd0 : csum_acc) + 16'(stream.out_pixel);

  always_ff @(posedge clk_in_100 or negedge arst_n) begin
    if (!arst_n) begin
      csum_acc   <= '0;
      checksum_o <= '0;
    end else if (pop) begin
      csum_acc <= csum_sum;
      if (stream.out_frame_last) checksum_o <= csum_sum;
    end
  end
`else
  assign checksum_o = '0;
`endif

endmodule
